bbox_overlay: RTL and testbench
===============================

BBOX_OVERLAY -- requirements
Module: bbox_overlay

Interface
REQ-001 SHALL expose parameter H_RES, default 640, meaning active pixels per line.
REQ-002 SHALL expose parameter V_RES, default 480, meaning active lines per frame.
REQ-003 SHALL expose parameters THR_R / THR_G / THR_B, defaults 8'd128 / 8'd100 / 8'd100, meaning object-pixel thresholds.
REQ-004 SHALL expose parameter MIN_COUNT, default 16, meaning the minimum object pixels for a valid box.
REQ-005 SHALL expose parameter BOX_COLOR, default 24'hFF0000, meaning the overlay colour {R,G,B}.
REQ-006 clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 de_in, h_sync_in, v_sync_in  in  1 each  active-high data enable and syncs from the video source.
REQ-009 pixel_in  in  24  {R[23:16],G[15:8],B[7:0]}.
REQ-010 de_out, h_sync_out, v_sync_out  out  1 each  input controls delayed to match the pixel path.
REQ-011 pixel_out  out  24  pass-through pixel, or BOX_COLOR on the box perimeter.
REQ-012 x_min, x_max, y_min, y_max  out  11 each  latched box of the last completed frame.
REQ-013 box_valid  out  1  latched box is valid.
REQ-014 obj_count  out  20  object-pixel count of the last completed frame.

Function
REQ-015 Object pixel SHALL be de_in & (R > THR_R) & (G < THR_G) & (B < THR_B), all comparisons unsigned.
REQ-016 x counter (11 b) SHALL count de_in-high cycles from 0 and clear on each de_in falling edge; y counter (11 b) SHALL increment on each de_in falling edge and clear on each v_sync_in rising edge.
REQ-017 Counters SHALL wrap modulo 2048 with no saturation; out-of-spec lines are not range-checked.
REQ-018 Accumulators acc_xmin/acc_ymin SHALL init to 2047, acc_xmax/acc_ymax to 0, acc_cnt to 0; each object pixel SHALL update min/max with its (x,y) and increment acc_cnt, which saturates at 2^20-1.
REQ-019 On a v_sync_in rising edge with frame_ok=1, the accumulators SHALL be copied to the outputs, box_valid SHALL become (acc_cnt >= MIN_COUNT), and the accumulators SHALL re-initialise in the same cycle.
REQ-020 frame_ok SHALL clear on reset and set on the first v_sync_in rising edge; a partial frame after reset is discarded, and the outputs are not updated.
REQ-021 A v_sync_in rising edge coinciding with de_in=1 SHALL take priority; that pixel is not accumulated.
REQ-022 Latency SHALL be 2 cycles: stage 1 registers the pixel, the controls, x/y and the object flag; stage 2 selects the output pixel.
REQ-023 pixel_out SHALL equal BOX_COLOR when box_valid=1, the delayed de=1 and the pixel lies on the perimeter; otherwise it SHALL equal the delayed pixel_in.
REQ-024 Perimeter SHALL be ((x==x_min | x==x_max) & y_min<=y<=y_max) | ((y==y_min | y==y_max) & x_min<=x<=x_max).
REQ-025 Overlay SHALL use the latched box; an update at the v_sync edge takes effect from the next frame's first pixel.
REQ-026 de_out, h_sync_out and v_sync_out SHALL be exact 2-cycle delays of their inputs, with no reshaping.

Reset
REQ-027 rst=1 SHALL, on the next clk edge, clear all outputs to 0 (pixel_out=0, box_valid=0, x_min..y_max=0, obj_count=0), clear frame_ok and the pipeline, and initialise the accumulators and counters per REQ-016/018.
REQ-028 Reset asserted mid-frame SHALL abort accumulation, and the following partial frame is discarded per REQ-020.

Verification
REQ-029 Inject a 640x480 frame that is black except a red 24'hFF0000 rectangle x=100..199, y=50..149 -> after the vs edge: x_min=100, x_max=199, y_min=50, y_max=149, obj_count=10000, box_valid=1.
REQ-030 Replay the same frame -> output pixels at (100,50), (199,120) and (150,149) = 24'hFF0000; (150,100) = input pixel; de_out/h_sync_out/v_sync_out lag their inputs by exactly 2 cycles.
REQ-031 Inject a frame with 15 object pixels (MIN_COUNT=16) -> box_valid=0, obj_count=15, pixel_out = input pixel everywhere.
REQ-032 Assert rst at line 200 of a frame containing an object, then run two frames -> no update at the first vs edge; update after the first full frame only.
REQ-033 Inject pixels with R=128 and R=129 while G=B=0 -> only R=129 is counted (strict threshold).
REQ-034 Assert v_sync_in rising in the same cycle as an object pixel at (639,479) -> the pixel is excluded; the latched box reflects the prior pixels only.

Source files
------------

// File: rtl/bbox_overlay.sv
// Bounding-box detector and overlay: finds the extent of threshold-matching pixels in each
// frame and draws that box over the following frame, with a 2-cycle video pipeline.
module bbox_overlay #(
   parameter int unsigned H_RES     = 640,
   parameter int unsigned V_RES     = 480,
   parameter logic [7:0]  THR_R     = 8'd128,
   parameter logic [7:0]  THR_G     = 8'd100,
   parameter logic [7:0]  THR_B     = 8'd100,
   parameter int unsigned MIN_COUNT = 16,
   parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        de_in,
   input  logic        h_sync_in,
   input  logic        v_sync_in,
   input  logic [23:0] pixel_in,
   output logic        de_out,
   output logic        h_sync_out,
   output logic        v_sync_out,
   output logic [23:0] pixel_out,
   output logic [10:0] x_min,
   output logic [10:0] x_max,
   output logic [10:0] y_min,
   output logic [10:0] y_max,
   output logic        box_valid,
   output logic [19:0] obj_count
);

   localparam logic [19:0] MIN_CNT = 20'(MIN_COUNT);

   if (H_RES == 0 || H_RES > 2048 || V_RES == 0 || V_RES > 2048) begin : g_bad_res
      $error("bbox_overlay: H_RES and V_RES must lie in 1..2048");
   end

   logic        de_d, vs_d;
   logic        de_fall, vs_rise, obj;
   logic [10:0] x_cnt, y_cnt;

   logic [23:0] s1_pix;
   logic        s1_de, s1_hs, s1_vs, s1_obj, s1_vs_rise;
   logic [10:0] s1_x, s1_y;

   logic [10:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
   logic [19:0] acc_cnt;
   logic        frame_ok;
   logic        perim;

   assign de_fall = de_d & ~de_in;
   assign vs_rise = v_sync_in & ~vs_d;
   assign obj     = de_in & (pixel_in[23:16] > THR_R) & (pixel_in[15:8] < THR_G)
                  & (pixel_in[7:0] < THR_B);

   always_ff @(posedge clk) begin
      if (rst) begin
         de_d  <= 1'b0;
         vs_d  <= 1'b0;
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         de_d <= de_in;
         vs_d <= v_sync_in;
         if (de_fall)    x_cnt <= '0;
         else if (de_in) x_cnt <= x_cnt + 11'd1;
         if (vs_rise)      y_cnt <= '0;
         else if (de_fall) y_cnt <= y_cnt + 11'd1;
      end
   end

   // Stage 1; a pixel that coincides with a vsync rise is dropped from accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_pix     <= '0;
         s1_de      <= 1'b0;
         s1_hs      <= 1'b0;
         s1_vs      <= 1'b0;
         s1_obj     <= 1'b0;
         s1_vs_rise <= 1'b0;
         s1_x       <= '0;
         s1_y       <= '0;
      end else begin
         s1_pix     <= pixel_in;
         s1_de      <= de_in;
         s1_hs      <= h_sync_in;
         s1_vs      <= v_sync_in;
         s1_obj     <= obj & ~vs_rise;
         s1_vs_rise <= vs_rise;
         s1_x       <= x_cnt;
         s1_y       <= y_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_xmin  <= '1;
         acc_ymin  <= '1;
         acc_xmax  <= '0;
         acc_ymax  <= '0;
         acc_cnt   <= '0;
         frame_ok  <= 1'b0;
         x_min     <= '0;
         x_max     <= '0;
         y_min     <= '0;
         y_max     <= '0;
         box_valid <= 1'b0;
         obj_count <= '0;
      end else if (s1_vs_rise) begin
         if (frame_ok) begin
            x_min     <= acc_xmin;
            x_max     <= acc_xmax;
            y_min     <= acc_ymin;
            y_max     <= acc_ymax;
            box_valid <= (acc_cnt >= MIN_CNT);
            obj_count <= acc_cnt;
         end
         frame_ok <= 1'b1;
         acc_xmin <= '1;
         acc_ymin <= '1;
         acc_xmax <= '0;
         acc_ymax <= '0;
         acc_cnt  <= '0;
      end else if (s1_obj) begin
         if (s1_x < acc_xmin) acc_xmin <= s1_x;
         if (s1_x > acc_xmax) acc_xmax <= s1_x;
         if (s1_y < acc_ymin) acc_ymin <= s1_y;
         if (s1_y > acc_ymax) acc_ymax <= s1_y;
         if (acc_cnt != '1) acc_cnt <= acc_cnt + 20'd1;
      end
   end

   always_comb begin
      perim = 1'b0;
      if ((s1_x == x_min || s1_x == x_max) && s1_y >= y_min && s1_y <= y_max)
         perim = 1'b1;
      if ((s1_y == y_min || s1_y == y_max) && s1_x >= x_min && s1_x <= x_max)
         perim = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_out  <= '0;
         de_out     <= 1'b0;
         h_sync_out <= 1'b0;
         v_sync_out <= 1'b0;
      end else begin
         pixel_out  <= (box_valid && s1_de && perim) ? BOX_COLOR : s1_pix;
         de_out     <= s1_de;
         h_sync_out <= s1_hs;
         v_sync_out <= s1_vs;
      end
   end

endmodule

// File: tb/tb_bbox_overlay.sv
// Directed bench for bbox_overlay on a reduced 24x16 raster; a scoreboard queue checks
// the delayed video stream every cycle and the latched box is checked after each vsync.
module tb_bbox_overlay;

   localparam int H  = 24;
   localparam int HB = 6;
   localparam int V  = 16;
   localparam logic [23:0] RED = 24'hFF0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
   logic [23:0] pixel_in = '0;
   logic        de_out, h_sync_out, v_sync_out, box_valid;
   logic [23:0] pixel_out;
   logic [10:0] x_min, x_max, y_min, y_max;
   logic [19:0] obj_count;

   always #5 clk = ~clk;

   bbox_overlay #(
      .H_RES(H), .V_RES(V), .THR_R(8'd128), .THR_G(8'd100), .THR_B(8'd100),
      .MIN_COUNT(16), .BOX_COLOR(RED)
   ) dut (
      .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .pixel_in(pixel_in), .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
      .pixel_out(pixel_out), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
      .box_valid(box_valid), .obj_count(obj_count)
   );

   int n_assert = 0;
   int n_fail   = 0;
   logic [26:0] sb_q[$];

   // Expected latched box as seen by the overlay, and the value it takes at the next vsync rise.
   int   b_xmn = 0, b_xmx = 0, b_ymn = 0, b_ymx = 0;
   logic b_valid = 1'b0;
   int   nb_xmn, nb_xmx, nb_ymn, nb_ymx;
   logic nb_valid;
   logic nb_update = 1'b0;
   logic m_vs_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic on_perim(input int x, input int y);
      return ((x == b_xmn || x == b_xmx) && y >= b_ymn && y <= b_ymx) ||
             ((y == b_ymn || y == b_ymx) && x >= b_xmn && x <= b_xmx);
   endfunction

   function automatic logic [23:0] pix_at(input int kind, input int x, input int y);
      logic [23:0] p;
      p = '0;
      case (kind)
         1, 4: begin
            if (x >= 5 && x <= 14 && y >= 3 && y <= 12) p = RED;
            if (kind == 4 && x == H - 1 && y == V - 1) p = RED;
         end
         2: if (y == 2 && x <= 14) p = RED;
         3: begin
            if (y == 4 && x <= 11) p = 24'h800000;
            if ((y == 5 || y == 6) && x >= 3 && x <= 12) p = 24'h810000;
            if (y == 8) p = 24'hFF6400;
            if (y == 9) p = 24'hFF0064;
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   task automatic set_next(input int xmn, input int xmx, input int ymn, input int ymx,
                           input logic v);
      nb_xmn = xmn; nb_xmx = xmx; nb_ymn = ymn; nb_ymx = ymx; nb_valid = v;
      nb_update = 1'b1;
   endtask

   task automatic cyc(input logic de, input logic hs, input logic vs, input logic [23:0] pix,
                      input int x, input int y);
      logic [23:0] epix;
      logic [26:0] exp_e;
      de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = pix;
      epix = (de && b_valid && on_perim(x, y)) ? RED : pix;
      if (vs && !m_vs_prev && nb_update) begin
         b_xmn = nb_xmn; b_xmx = nb_xmx; b_ymn = nb_ymn; b_ymx = nb_ymx; b_valid = nb_valid;
         nb_update = 1'b0;
      end
      m_vs_prev = vs;
      sb_q.push_back({de, hs, vs, epix});
      @(posedge clk); #1;
      if (sb_q.size() == 2) begin
         exp_e = sb_q.pop_front();
         chk("pipe", {5'b0, de_out, h_sync_out, v_sync_out, pixel_out}, {5'b0, exp_e});
      end
   endtask

   task automatic active(input int kind, input int y0, input int y1, input logic vs_last);
      for (int y = y0; y <= y1; y++) begin
         for (int x = 0; x < H; x++)
            cyc(1'b1, 1'b0, vs_last && y == y1 && x == H - 1, pix_at(kind, x, y), x, y);
         for (int b = 0; b < HB; b++)
            cyc(1'b0, b == 1 || b == 2, vs_last && y == y1, 24'($urandom), 0, 0);
      end
   endtask

   task automatic vs_pulse();
      for (int l = 0; l < 3; l++)
         for (int c = 0; c < H + HB; c++)
            cyc(1'b0, c == H + 1 || c == H + 2, l < 2, 24'($urandom), 0, 0);
   endtask

   task automatic chk_box(input string tag, input int xmn, input int xmx, input int ymn,
                          input int ymx, input int cnt, input logic v);
      chk({tag, ".x_min"}, 32'(x_min), xmn);
      chk({tag, ".x_max"}, 32'(x_max), xmx);
      chk({tag, ".y_min"}, 32'(y_min), ymn);
      chk({tag, ".y_max"}, 32'(y_max), ymx);
      chk({tag, ".obj_count"}, 32'(obj_count), cnt);
      chk({tag, ".box_valid"}, 32'(box_valid), 32'(v));
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = '0;
      @(posedge clk); #1;
      chk({tag, ".pixel_out"}, 32'(pixel_out), 0);
      chk({tag, ".ctl_out"}, 32'({de_out, h_sync_out, v_sync_out}), 0);
      chk_box(tag, 0, 0, 0, 0, 0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      sb_q.delete();
      m_vs_prev = 1'b0;
      b_xmn = 0; b_xmx = 0; b_ymn = 0; b_ymx = 0; b_valid = 1'b0;
      nb_update = 1'b0;
   endtask

   initial begin
      do_reset("reset");

      // First vsync after reset only arms frame capture.
      vs_pulse();
      chk_box("first_vs", 0, 0, 0, 0, 0, 1'b0);

      active(1, 0, V - 1, 1'b0);
      set_next(5, 14, 3, 12, 1'b1);
      vs_pulse();
      chk_box("rect", 5, 14, 3, 12, 100, 1'b1);

      active(1, 0, V - 1, 1'b0);
      set_next(5, 14, 3, 12, 1'b1);
      vs_pulse();
      chk_box("rect_replay", 5, 14, 3, 12, 100, 1'b1);

      // Black frame: overlay perimeter is the only non-black content.
      active(0, 0, V - 1, 1'b0);
      set_next(2047, 0, 2047, 0, 1'b0);
      vs_pulse();
      chk_box("empty", 2047, 0, 2047, 0, 0, 1'b0);

      active(2, 0, V - 1, 1'b0);
      set_next(0, 14, 2, 2, 1'b0);
      vs_pulse();
      chk_box("count15", 0, 14, 2, 2, 15, 1'b0);

      active(3, 0, V - 1, 1'b0);
      set_next(3, 12, 5, 6, 1'b1);
      vs_pulse();
      chk_box("thresh", 3, 12, 5, 6, 20, 1'b1);

      // Object pixel at the last position coincides with the vsync rise.
      active(4, 0, V - 1, 1'b1);
      set_next(5, 14, 3, 12, 1'b1);
      vs_pulse();
      chk_box("vs_pixel", 5, 14, 3, 12, 100, 1'b1);
      set_next(2047, 0, 2047, 0, 1'b0);
      vs_pulse();
      chk_box("realign", 2047, 0, 2047, 0, 0, 1'b0);

      // Reset mid-frame: remaining partial frame is discarded, next full frame is captured.
      active(1, 0, 7, 1'b0);
      do_reset("mid_reset");
      active(1, 8, V - 1, 1'b0);
      vs_pulse();
      chk_box("after_partial", 0, 0, 0, 0, 0, 1'b0);
      active(1, 0, V - 1, 1'b0);
      set_next(5, 14, 3, 12, 1'b1);
      vs_pulse();
      chk_box("after_full", 5, 14, 3, 12, 100, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
